// File: rtl/spike_rate_decoder_if.sv
// spike_rate_decoder_if
//   Valid/ready result port of the spike rate decoder.
//   rate_data  : 8-bit spike count of the last completed window
//   rate_valid : rate_data holds an unconsumed result
//   rate_ready : consumer accepts rate_data when high together with rate_valid
//   master = decoder (producer), slave = consumer.
interface spike_rate_decoder_if;
  logic [7:0] rate_data;
  logic       rate_valid;
  logic       rate_ready;

  modport master (output rate_data, output rate_valid, input rate_ready);
  modport slave  (input rate_data, input rate_valid, output rate_ready);
endinterface

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder
//   Reconstructs an 8-bit activity value from a 1-bit spike train by counting
//   spikes over back-to-back windows of WINDOW cycles, and measures the
//   inter-spike interval between consecutive spikes.
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   en         decode enable; low returns the decoder to IDLE
//   spike      spike train, sampled every clock
//   rate       valid/ready result port (master side)
//   isi        cycles between the two most recent spikes, saturating at 255
//   isi_valid  one-cycle pulse when isi updates
//   overrun    sticky; a window result was dropped under backpressure
module spike_rate_decoder #(
  parameter int WINDOW = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        spike,
  spike_rate_decoder_if.master        rate,
  output logic [7:0]                  isi,
  output logic                        isi_valid,
  output logic                        overrun
);

  localparam int WCW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WCW-1:0] WIN_LAST = WCW'(WINDOW - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state, state_nxt;
  logic [WCW-1:0] win_cnt;
  logic [7:0]     spk_cnt;
  logic [7:0]     gap_cnt;
  logic           have_prev;

  // Counter views as seen this cycle. In IDLE the registers are already
  // clear, but masking by state keeps the first RUN cycle exactly at
  // window cycle 0 regardless of what was left behind.
  logic [WCW-1:0] win_cur;
  logic [7:0]     spk_cur;
  logic [7:0]     gap_cur;
  logic           prev_cur;

  logic           win_end;
  logic [7:0]     spk_sum;
  logic [7:0]     gap_inc;
  logic           out_free;
  logic           load;
  logic           drop;
  logic           xfer;
  logic           isi_upd;

  always_comb begin
    state_nxt = state;
    win_cur   = '0;
    spk_cur   = '0;
    gap_cur   = '0;
    prev_cur  = 1'b0;

    case (state)
      IDLE: if (en) state_nxt = RUN;
      RUN: begin
        win_cur  = win_cnt;
        spk_cur  = spk_cnt;
        gap_cur  = gap_cnt;
        prev_cur = have_prev;
        if (!en) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    // The enabling cycle itself counts, so window logic keys off en rather
    // than the registered state.
    win_end  = en && (win_cur == WIN_LAST);
    spk_sum  = (spike && spk_cur != 8'hFF) ? spk_cur + 8'd1 : spk_cur;
    gap_inc  = (gap_cur != 8'hFF) ? gap_cur + 8'd1 : gap_cur;
    xfer     = rate.rate_valid && rate.rate_ready;
    // Output register is free if empty or being drained this very cycle.
    out_free = !rate.rate_valid || rate.rate_ready;
    load     = win_end && out_free;
    drop     = win_end && !out_free;
    isi_upd  = en && spike && prev_cur;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      win_cnt         <= '0;
      spk_cnt         <= '0;
      gap_cnt         <= '0;
      have_prev       <= 1'b0;
      rate.rate_data  <= '0;
      rate.rate_valid <= 1'b0;
      isi             <= '0;
      isi_valid       <= 1'b0;
      overrun         <= 1'b0;
    end else begin
      state <= state_nxt;

      if (en) begin
        win_cnt <= win_end ? '0 : win_cur + WCW'(1);
        spk_cnt <= win_end ? '0 : spk_sum;
        if (spike) begin
          gap_cnt   <= 8'd1;
          have_prev <= 1'b1;
        end else begin
          gap_cnt   <= gap_inc;
        end
      end else begin
        win_cnt   <= '0;
        spk_cnt   <= '0;
        gap_cnt   <= '0;
        have_prev <= 1'b0;
      end

      isi_valid <= isi_upd;
      if (isi_upd) isi <= gap_cur;

      // Simultaneous consume+load keeps rate_valid high with the new value.
      if (load) begin
        rate.rate_data  <= spk_sum;
        rate.rate_valid <= 1'b1;
      end else if (xfer) begin
        rate.rate_valid <= 1'b0;
      end

      if (drop) overrun <= 1'b1;
    end
  end

endmodule
